mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequential arbiter that shares the single-ported RAM between the instruction-cache path (iREN) and the data-cache path (dREN/dWEN).
- Sits between the cache interfaces and the RAM model; replaces direct wiring of the datapath's imem/dmem requests to memory.
- Latches the granted request and holds it stable on the RAM port until RAM reports ACCESS.
- Data side has priority; a fairness counter bounds instruction-fetch starvation.

Parameters:
- IFAIR, 4: max consecutive data grants while iREN is pending before instruction side is forced a grant. Legal range 1..15.
- WORD_W, 32: address/data width (word_t).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request; held until iwait=0.
- iaddr  in  32  instruction address.
- iwait  out  1  0 for exactly the completion cycle of an instruction read.
- iload  out  32  instruction read data, valid when iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; takes precedence over dREN if both are high.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  0 for exactly the completion cycle of a data access.
- dload  out  32  data read data, valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE; ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Fairness counter dcnt=0; iwait=1, dwait=1.
- States: IDLE, IACC, DACC. ramREN, ramWEN, ramaddr and ramstore are registered outputs.
- IDLE, evaluated each edge:
  - If (dREN|dWEN), and not (iREN && dcnt==IFAIR): go to DACC. Latch ramaddr=daddr. If dWEN: ramWEN=1, ramstore=dstore. Otherwise ramREN=1.
  - Else if iREN: go to IACC. Latch ramaddr=iaddr, ramREN=1.
  - Else stay in IDLE with all RAM enables 0.
- IACC/DACC:
  - Hold latched RAM outputs unchanged while ramstate is FREE or BUSY.
  - ramstate=ACCESS: combinationally drive the granted side's wait=0 in that cycle; iload/dload pass ramload through. Next edge: go to IDLE and clear ramREN/ramWEN.
  - ramstate=ERROR: retry. Stay in the state with the same outputs; wait stays 1.
- Wait outputs: iwait = !(state==IACC && ramstate==ACCESS); dwait = !(state==DACC && ramstate==ACCESS). The non-granted side sees wait=1 throughout.
- Latency: request seen in IDLE at edge N, RAM driven from N+1. With zero-wait RAM (ACCESS in the first driven cycle), wait=0 in cycle N+1, so minimum latency is 1 cycle after arbitration. A back-to-back request is re-arbitrated in the IDLE cycle after completion (one bubble).
- Fairness counter dcnt (4 bits, saturating at IFAIR):
  - Increments on each DACC grant while iREN=1.
  - Clears on an IACC grant, or at any IDLE edge with iREN=0.
  - When dcnt==IFAIR and iREN=1, IDLE grants IACC even if a data request is pending.
- Request withdrawn mid-access: the latched operation runs to ACCESS. Its result is discarded (wait pulse still produced); then return to IDLE.
- Simultaneous dREN and dWEN: treated as a write.
- Reset mid-access: immediate abort to reset values; the RAM sees its enables drop asynchronously.
- ramload is never registered; iload and dload equal ramload at all times.

Decomposition:
- cpu_types_pkg already holds word_t and ramstate_t. Add arb_state_t {IDLE, IACC, DACC} and the constant ARB_IFAIR_DEFAULT=4.
- No sub-module; the fairness counter is a single always_ff. The next-state/output logic is split into always_ff (state, latches, counter) and always_comb (next state, waits).

Test Plan:
- Reset with iREN=1, dREN=1 asserted → ramREN=0, iwait=dwait=1. After release, first grant is DACC with ramaddr=daddr.
- iREN=1, iaddr=0x40; RAM returns BUSY for 2 cycles, then ACCESS with ramload=0x8C220004 → iwait=0 for exactly one cycle, iload=0x8C220004, then IDLE with ramREN=0.
- dWEN=1 and dREN=1, daddr=0x80, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, held until ACCESS; dwait pulses once.
- iREN held high, with a data request re-asserted after every completion (IFAIR=4) → exactly 4 DACC grants, then one IACC grant, then dcnt=0.
- ramstate=ERROR for 3 cycles during DACC (daddr=0x100) → outputs unchanged, dwait=1. Then ACCESS → dwait=0 once, dload=ramload.
- nRST pulsed low during IACC with ramstate=BUSY → ramREN drops to 0 asynchronously, state=IDLE, iwait=1. After release, the pending request is re-arbitrated.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM handshake state and the memory arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    localparam int ARB_IFAIR_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single-ported RAM between the icache and dcache paths.
// Data side wins arbitration; dcnt bounds how long a pending ifetch can be starved.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int IFAIR  = ARB_IFAIR_DEFAULT,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    arb_state_t state, nstate;
    logic [3:0] dcnt;
    logic       access;
    logic       dreq;
    logic       ifair_hit;

    assign iload = ramload;
    assign dload = ramload;

    always_comb begin
        access    = (ramstate == ACCESS);
        dreq      = dREN | dWEN;
        ifair_hit = iREN && (dcnt == 4'(IFAIR));
        nstate    = state;
        case (state)
            IDLE: begin
                if (dreq && !ifair_hit) nstate = DACC;
                else if (iREN)          nstate = IACC;
            end
            IACC, DACC: begin
                // ERROR keeps the state so the same access is retried
                if (access) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        iwait = !((state == IACC) && access);
        dwait = !((state == DACC) && access);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            state <= nstate;
            case (state)
                IDLE: begin
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                    if (nstate == DACC) begin
                        ramaddr <= daddr;
                        if (dWEN) begin
                            ramWEN   <= 1'b1;
                            ramstore <= dstore;
                        end else begin
                            ramREN <= 1'b1;
                        end
                    end else if (nstate == IACC) begin
                        ramaddr <= iaddr;
                        ramREN  <= 1'b1;
                    end
                end
                default: begin
                    if (access) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Counts data grants that overtook a waiting ifetch; only moves in IDLE
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dcnt <= '0;
        end else if (state == IDLE) begin
            if (!iREN || nstate == IACC)
                dcnt <= '0;
            else if (nstate == DACC && dcnt < 4'(IFAIR))
                dcnt <= dcnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int IFAIR = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    ramstate_t   ramstate = FREE;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;

    // Model: who holds the RAM (0 none, 1 instr, 2 data), the latched op, data streak
    int          m_gnt = 0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic        m_wr = 1'b0;
    int          m_streak = 0;

    mem_arbiter #(.IFAIR(IFAIR), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_gnt = 0; m_addr = '0; m_data = '0; m_wr = 1'b0; m_streak = 0;
    endtask

    // Advance one clock, applying the arbitration rules to the model at the edge
    task automatic tick();
        @(posedge CLK);
        if (!nRST) begin
            model_reset();
        end else if (m_gnt == 0) begin
            if ((dREN || dWEN) && !(iREN && m_streak >= IFAIR)) begin
                m_gnt = 2; m_addr = daddr; m_wr = dWEN;
                if (dWEN) m_data = dstore;
                m_streak = iREN ? m_streak + 1 : 0;
            end else if (iREN) begin
                m_gnt = 1; m_addr = iaddr; m_wr = 1'b0; m_streak = 0;
            end else begin
                m_streak = 0;
            end
        end else if (ramstate == ACCESS) begin
            m_gnt = 0;
        end
        #1;
    endtask

    task automatic end_all();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = ACCESS;
        tick(); tick();
        ramstate = FREE;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h22; daddr = 32'h11;
        ramstate = ACCESS;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ren got=%b exp=0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_wen got=%b exp=0", ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", ramaddr); end
        checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rst_wait got=%b%b exp=11", iwait, dwait); end
        tick(); tick();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_hold_ren got=%b exp=0", ramREN); end
        nRST = 1'b1; ramstate = FREE;
        tick();
        ramstate = BUSY; #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h11) begin errors++; $display("FAIL rst_first_grant got=%b/%h exp=1/00000011", ramREN, ramaddr); end
        ramstate = ACCESS; #1;
        checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL rst_first_done got=%b%b exp=10", iwait, dwait); end
        end_all();
    endtask

    task automatic test_ifetch();
        iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
        tick();
        for (int k = 0; k < 2; k++) begin
            ramstate = BUSY; #1;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
                errors++; $display("FAIL if_busy got=%b/%h/%b exp=1/00000040/1", ramREN, ramaddr, iwait); end
            tick();
        end
        ramstate = ACCESS; ramload = 32'h8C220004; #1;
        checks++; if (iwait !== 1'b0 || iload !== 32'h8C220004) begin
            errors++; $display("FAIL if_done got=%b/%h exp=0/8c220004", iwait, iload); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL if_dwait got=%b exp=1", dwait); end
        iREN = 1'b0;
        tick();
        ramstate = FREE; #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            errors++; $display("FAIL if_after got=%b/%b exp=0/1", ramREN, iwait); end
        end_all();
    endtask

    task automatic test_write_priority();
        int pulses = 0;
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = FREE;
        tick();
        ramstate = BUSY; #1;
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h80) begin
            errors++; $display("FAIL wr_latch got=%b%b/%h/%h exp=10/deadbeef/00000080", ramWEN, ramREN, ramstore, ramaddr); end
        dWEN = 1'b0; dREN = 1'b0; dstore = 32'h0;
        for (int k = 0; k < 4; k++) begin
            ramstate = (k == 2) ? ACCESS : BUSY; #1;
            if (dwait === 1'b0) pulses++;
            if (k < 2) begin
                checks++; if (ramWEN !== 1'b1 || ramstore !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL wr_hold got=%b/%h exp=1/deadbeef", ramWEN, ramstore); end
            end
            tick();
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL wr_pulses got=%0d exp=1", pulses); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL wr_clear got=%b exp=0", ramWEN); end
        end_all();
    endtask

    task automatic test_fairness();
        int got[10];
        int n = 0;
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS;
        for (int c = 0; c < 40 && n < 10; c++) begin
            tick();
            if (ramREN === 1'b1) begin
                got[n] = (ramaddr == 32'h200) ? 1 : 2;
                if (got[n] == 1) begin
                    checks++; if (iwait !== 1'b0 || dwait !== 1'b1) begin
                        errors++; $display("FAIL fair_iwait got=%b%b exp=01", iwait, dwait); end
                end
                n++;
            end
        end
        checks++; if (n != 10) begin errors++; $display("FAIL fair_timeout got=%0d grants exp=10", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got[i] != ((i % 5 == 4) ? 1 : 2)) begin
                errors++; $display("FAIL fair_seq[%0d] got=%0d exp=%0d", i, got[i], (i % 5 == 4) ? 1 : 2); end
        end
        end_all();
    endtask

    task automatic test_error_retry();
        logic [31:0] v;
        dREN = 1'b1; daddr = 32'h100; ramstate = FREE;
        tick();
        for (int k = 0; k < 3; k++) begin
            ramstate = ERROR; #1;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 1'b1) begin
                errors++; $display("FAIL err_hold got=%b/%h/%b exp=1/00000100/1", ramREN, ramaddr, dwait); end
            tick();
        end
        v = $urandom; ramload = v; ramstate = ACCESS; #1;
        checks++; if (dwait !== 1'b0 || dload !== v) begin
            errors++; $display("FAIL err_done got=%b/%h exp=0/%h", dwait, dload, v); end
        dREN = 1'b0;
        tick();
        ramstate = FREE; #1;
        checks++; if (dwait !== 1'b1 || ramREN !== 1'b0) begin
            errors++; $display("FAIL err_after got=%b/%b exp=1/0", dwait, ramREN); end
        end_all();
    endtask

    task automatic test_reset_mid();
        iREN = 1'b1; iaddr = 32'h44; ramstate = FREE;
        tick();
        ramstate = BUSY; #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rm_pre got=%b exp=1", ramREN); end
        #1 nRST = 1'b0; model_reset(); ramstate = ACCESS; #1;
        checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1) begin
            errors++; $display("FAIL rm_async got=%b/%h/%b exp=0/00000000/1", ramREN, ramaddr, iwait); end
        tick();
        nRST = 1'b1; ramstate = FREE;
        tick();
        ramstate = BUSY; #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
            errors++; $display("FAIL rm_rearb got=%b/%h exp=1/00000044", ramREN, ramaddr); end
        end_all();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            iREN = 1'($urandom_range(0, 1)); dREN = 1'($urandom_range(0, 1));
            dWEN = ($urandom_range(0, 3) == 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = ramstate_t'($urandom_range(0, 3));
            #1;
            checks++; if (ramREN !== ((m_gnt == 1) || (m_gnt == 2 && !m_wr))) begin
                errors++; $display("FAIL rnd_ren c=%0d got=%b gnt=%0d", c, ramREN, m_gnt); end
            checks++; if (ramWEN !== (m_gnt == 2 && m_wr)) begin
                errors++; $display("FAIL rnd_wen c=%0d got=%b gnt=%0d", c, ramWEN, m_gnt); end
            checks++; if (ramaddr !== m_addr || ramstore !== m_data) begin
                errors++; $display("FAIL rnd_latch c=%0d got=%h/%h exp=%h/%h", c, ramaddr, ramstore, m_addr, m_data); end
            checks++; if (iwait !== !(m_gnt == 1 && ramstate == ACCESS) || dwait !== !(m_gnt == 2 && ramstate == ACCESS)) begin
                errors++; $display("FAIL rnd_wait c=%0d got=%b%b gnt=%0d", c, iwait, dwait, m_gnt); end
            checks++; if (iload !== ramload || dload !== ramload) begin
                errors++; $display("FAIL rnd_load c=%0d got=%h/%h exp=%h", c, iload, dload, ramload); end
            tick();
        end
        end_all();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_write_priority();
        test_fairness();
        test_error_retry();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
